// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the ROM instruction fetch unit.
//   state_e       : fetch FSM states (IDLE, ADDR, WAIT)
//   WORD_BYTES    : byte stride between consecutive instruction words
//   fetch_entry_t : one prefetch FIFO entry {pc, data} at the default PC width
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2
   } state_e;

   localparam int WORD_BYTES     = 4;
   localparam int DEFAULT_ADDR_W = 17;

   typedef struct packed {
      logic [DEFAULT_ADDR_W-1:0] pc;
      logic [31:0]               data;
   } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_unit_if.sv
// rom_fetch_unit_if: bundles the ROM read port and the decode-side handshake.
//   ROM side    : rom_en, rom_rw, rom_addr (to ROM), rom_data (from ROM)
//   decode side : instr_valid, instr_data, instr_pc (to decode), instr_ready (from decode)
// Handshake: a word transfers on a rising edge where instr_valid=1 and
// instr_ready=1. While instr_valid=1 and no transfer happens, instr_data and
// instr_pc hold. instr_valid never depends on instr_ready in the same cycle;
// decode may drive instr_ready independently of instr_valid.
// Modports: master = fetch unit, slave = ROM plus decode stage.
interface rom_fetch_unit_if #(
   parameter int ADDR_W = 17
);
   logic              rom_en;
   logic              rom_rw;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr_data;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output rom_en, rom_rw, rom_addr,
      input  rom_data,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  rom_en, rom_rw, rom_addr,
      output rom_data,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetched {pc, data} entries.
//   clk, reset_n : clock, asynchronous active-low reset
//   push/wr_entry: write an entry at the tail
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; overrides push and pop on the same edge
//   rd_entry     : head entry (registered storage, no output logic)
//   count/full/empty : occupancy
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 wr_entry,
   output entry_t                 rd_entry,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               do_push, do_pop;

   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign rd_entry = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && !flush && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
         rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
         count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Storage is reset too so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
         end
      end
   end
endmodule

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: instruction fetch stage in front of the program ROM.
//   clk, reset_n  : clock, asynchronous active-low reset
//   fetch_en      : allows new ROM requests (an in-flight one always completes)
//   redirect      : one-cycle pulse, loads pc from redirect_pc and flushes
//   redirect_pc   : new pc, low two bits forced to zero
//   bus (master)  : ROM read port and decode valid/ready handshake
//   dbg_state     : current fetch FSM state
// One request is in flight at a time and a request only starts with a free
// FIFO slot, so the capture push can never overflow.
module rom_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W      = DEFAULT_ADDR_W,
   parameter int                DEPTH       = 4,
   parameter int                WAIT_CYCLES = 1,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_en,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   rom_fetch_unit_if.master  bus,
   output state_e            dbg_state
);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       data;
   } entry_t;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rom_en_q, rom_en_d;
   logic              push, pop, capture, room;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   entry_t            wr_entry, rd_entry;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .pop      (pop),
      .flush    (redirect),
      .wr_entry (wr_entry),
      .rd_entry (rd_entry),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cnt_d         = cnt_q;
      push          = 1'b0;
      wr_entry.pc   = pc_q;
      wr_entry.data = bus.rom_data;
      // A coincident redirect discards the pop along with the FIFO contents.
      pop     = !fifo_empty && bus.instr_ready && !redirect;
      capture = (state_q == WAIT) && (cnt_q == '0);
      // Count is at most DEPTH-1 at a capture, so post-push count < DEPTH
      // holds exactly when a pop frees a slot or one more slot is spare.
      room    = pop || (fifo_count < CW'(DEPTH - 1));

      if (redirect) begin
         pc_d    = redirect_pc & ~ADDR_W'(3);
         state_d = fetch_en ? ADDR : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (fetch_en && !fifo_full) state_d = ADDR;
            end
            ADDR: begin
               state_d = WAIT;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            WAIT: begin
               if (capture) begin
                  push    = 1'b1;
                  pc_d    = pc_q + ADDR_W'(WORD_BYTES);
                  state_d = (fetch_en && room) ? ADDR : IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      rom_en_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         cnt_q    <= '0;
         rom_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         rom_en_q <= rom_en_d;
      end
   end

   // pc only changes on leaving WAIT or on redirect, so it doubles as the
   // held ROM address for the whole request.
   assign bus.rom_en      = rom_en_q;
   assign bus.rom_rw      = 1'b1;
   assign bus.rom_addr    = pc_q;
   assign bus.instr_valid = !fifo_empty;
   assign bus.instr_data  = rd_entry.data;
   assign bus.instr_pc    = rd_entry.pc;
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: bench for rom_fetch_unit. A ROM array feeds two units
// (WAIT_CYCLES=1 and WAIT_CYCLES=3). The reference model treats the decode
// side as an in-order word stream: the head must always be the next expected
// pc with the ROM word stored at that pc; redirects restart the stream.
module tb_rom_fetch_unit;
   import fetch_pkg::*;

   localparam int                ADDR_W    = 17;
   localparam int                ROM_WORDS = 1 << (ADDR_W - 2);
   localparam logic [ADDR_W-1:0] RST_PC    = '0;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              fetch_en = 1'b0;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic              fetch_en3 = 1'b0;
   state_e            dbg_state, dbg_state3;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rom_mem [ROM_WORDS];
   logic [31:0] lits [4];

   rom_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();
   rom_fetch_unit_if #(.ADDR_W(ADDR_W)) bus3 ();

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- ROM model ----------------
   assign bus.rom_data  = bus.rom_en  ? rom_mem[bus.rom_addr[ADDR_W-1:2]]  : 32'hBAD0_BAD0;
   assign bus3.rom_data = bus3.rom_en ? rom_mem[bus3.rom_addr[ADDR_W-1:2]] : 32'hBAD0_BAD0;

   rom_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(4), .WAIT_CYCLES(1), .RESET_PC(RST_PC)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_en    (fetch_en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus),
      .dbg_state   (dbg_state)
   );

   rom_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(4), .WAIT_CYCLES(3), .RESET_PC(RST_PC)) u_dut3 (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_en    (fetch_en3),
      .redirect    (1'b0),
      .redirect_pc ('0),
      .bus         (bus3),
      .dbg_state   (dbg_state3)
   );

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   logic [ADDR_W-1:0] model_pc = RST_PC;
   bit                expect_empty = 1'b0;
   logic [ADDR_W-1:0] pop_log [$];

   // Outputs are compared at the falling edge; inputs are stable from here to
   // the next rising edge, so the model also steps here for that edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         model_pc     = RST_PC;
         expect_empty = 1'b0;
      end else begin
         check("rom_rw", bus.rom_rw, 1);
         if (bus.rom_en) check("rom_addr_align", bus.rom_addr[1:0], 0);
         if (expect_empty) check("flush_valid", bus.instr_valid, 0);
         if (bus.instr_valid) begin
            check("head_pc", bus.instr_pc, model_pc);
            check("head_data", bus.instr_data, rom_mem[model_pc[ADDR_W-1:2]]);
         end
         expect_empty = 1'b0;
         if (redirect) begin
            model_pc     = redirect_pc & ~ADDR_W'(3);
            expect_empty = 1'b1;
         end else if (bus.instr_valid && bus.instr_ready) begin
            pop_log.push_back(model_pc);
            model_pc = model_pc + ADDR_W'(4);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for_wait(input string name);
      int n = 0;
      while (dbg_state != WAIT && n < 50) begin
         step();
         n++;
      end
      check(name, dbg_state == WAIT, 1);
   endtask

   task automatic wait_for_valid(input string name);
      int n = 0;
      while (!bus.instr_valid && n < 50) begin
         step();
         n++;
      end
      check(name, bus.instr_valid, 1);
   endtask

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL watchdog: simulation did not finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
      lits[0] = 32'h1111_AAAA;
      lits[1] = 32'h2222_BBBB;
      lits[2] = 32'h3333_CCCC;
      lits[3] = 32'h4444_DDDD;
      for (int i = 0; i < 4; i++) rom_mem[i] = lits[i];
      bus.instr_ready  = 1'b1;
      bus3.instr_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_rom_en", bus.rom_en, 0);
      check("rst_rom_rw", bus.rom_rw, 1);
      check("rst_rom_addr", bus.rom_addr, RST_PC);
      check("rst_valid", bus.instr_valid, 0);
      check("rst_data", bus.instr_data, 0);
      check("rst_pc", bus.instr_pc, 0);
      check("rst_state", dbg_state, IDLE);
      reset_n = 1'b1;
      step();
      step();
      check("idle_no_fetch", bus.rom_en, 0);

      // Streaming from reset: A,B,C,D one word every two cycles
      fetch_en = 1'b1;
      step();                                   // E0
      check("e0_rom_en", bus.rom_en, 1);
      check("e0_rom_addr", bus.rom_addr, 17'h0);
      step();                                   // E1
      check("e1_valid", bus.instr_valid, 0);
      for (int k = 0; k < 4; k++) begin
         step();                                // E(2+2k)
         check("stream_valid", bus.instr_valid, 1);
         check("stream_pc", bus.instr_pc, 17'(4 * k));
         check("stream_data", bus.instr_data, lits[k]);
         step();                                // E(3+2k)
         check("stream_gap", bus.instr_valid, 0);
      end

      // Backpressure: FIFO fills, FSM parks, then drains in order
      bus.instr_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 17'h0;
      step();
      redirect = 1'b0;
      repeat (20) step();
      check("park_rom_en", bus.rom_en, 0);
      check("park_state", dbg_state, IDLE);
      check("park_valid", bus.instr_valid, 1);
      check("park_pc", bus.instr_pc, 17'h0);
      check("park_data", bus.instr_data, lits[0]);
      bus.instr_ready = 1'b1;
      repeat (4) step();
      check("resume_valid", bus.instr_valid, 1);
      check("resume_pc", bus.instr_pc, 17'h10);
      check("resume_data", bus.instr_data, rom_mem[4]);

      // Redirect on a capture edge
      wait_for_wait("t3_reach_wait");
      redirect    = 1'b1;
      redirect_pc = 17'h1003;
      step();
      redirect = 1'b0;
      check("redir_valid", bus.instr_valid, 0);
      step();
      check("redir_rom_en", bus.rom_en, 1);
      check("redir_rom_addr", bus.rom_addr, 17'h1000);
      wait_for_valid("redir_word_timeout");
      check("redir_pc", bus.instr_pc, 17'h1000);
      check("redir_data", bus.instr_data, rom_mem[17'h1000 >> 2]);

      // PC wrap at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 17'h1FFF8;
      step();
      redirect = 1'b0;
      pop_log.delete();
      repeat (16) step();
      check("wrap_count", pop_log.size() >= 3, 1);
      if (pop_log.size() >= 3) begin
         check("wrap_pc0", pop_log[0], 17'h1FFF8);
         check("wrap_pc1", pop_log[1], 17'h1FFFC);
         check("wrap_pc2", pop_log[2], 17'h00000);
      end

      // Reset during WAIT
      wait_for_wait("t5_reach_wait");
      reset_n = 1'b0;
      #1;
      check("arst_rom_en", bus.rom_en, 0);
      check("arst_rom_addr", bus.rom_addr, RST_PC);
      check("arst_valid", bus.instr_valid, 0);
      check("arst_data", bus.instr_data, 0);
      check("arst_pc", bus.instr_pc, 0);
      check("arst_state", dbg_state, IDLE);
      step();
      reset_n = 1'b1;
      step();
      check("arst_refetch_en", bus.rom_en, 1);
      check("arst_refetch_addr", bus.rom_addr, RST_PC);

      // Randomized traffic against the stream model
      for (int i = 0; i < 3000; i++) begin
         fetch_en        = ($urandom_range(0, 9) != 0);
         bus.instr_ready = ($urandom_range(0, 3) != 0);
         redirect        = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) redirect_pc = 17'h1FFF0 + 17'($urandom_range(0, 15));
         else                           redirect_pc = 17'($urandom);
         step();
      end
      redirect        = 1'b0;
      bus.instr_ready = 1'b1;
      fetch_en        = 1'b0;

      // WAIT_CYCLES=3 unit: fetch_en drops during WAIT
      fetch_en3 = 1'b1;
      step();                                   // Ea
      check("w3_rom_en", bus3.rom_en, 1);
      check("w3_rom_addr", bus3.rom_addr, RST_PC);
      check("w3_state", dbg_state3, ADDR);
      fetch_en3 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();                                // Ea+1 .. Ea+3
         check("w3_not_yet", bus3.instr_valid, 0);
         check("w3_rom_held", bus3.rom_en, 1);
      end
      step();                                   // Ea+4
      check("w3_valid", bus3.instr_valid, 1);
      check("w3_pc", bus3.instr_pc, RST_PC);
      check("w3_data", bus3.instr_data, lits[0]);
      check("w3_idle", bus3.rom_en, 0);
      for (int k = 0; k < 6; k++) begin
         step();
         check("w3_no_request", bus3.rom_en, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
